// File: rtl/cell_pos_reader.sv
`default_nettype none
// ============================================================================
// Module   : cell_pos_reader
// Function : Reads one cell's particle count and positions from a 2-cycle
//            latency RAM and streams them out over valid/ready with a
//            credit-protected output FIFO. CELL_POS_READER_BOUNDS_CHK_EN
//            enables count clamping and the sticky cnt_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_cnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  cnt_err
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_occ_w = c_ptr_w + 2;

    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_two = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] c_max_cnt  = ADDR_WIDTH'(PARTICLE_NUM - 1);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_cnt_rd   = 3'd1;
    localparam logic [2:0] c_st_cnt_wait = 3'd2;
    localparam logic [2:0] c_st_stream   = 3'd3;
    localparam logic [2:0] c_st_drain    = 3'd4;
    localparam logic [2:0] c_st_done     = 3'd5;

    logic [2:0]            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_particle_cnt;
    logic                  r_cnt_err;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_rden;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [1:0]            r_pend;
    logic [ADDR_WIDTH-1:0] r_pend_addr0;
    logic [ADDR_WIDTH-1:0] r_pend_addr1;

    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_idx  [FIFO_DEPTH];
    logic                  r_fifo_last [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_fifo_cnt;

    logic                  w_fifo_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_push_last;
    logic                  w_head_last;
    logic [c_occ_w-1:0]    w_occ;
    logic                  w_credit;
    logic [ADDR_WIDTH-1:0] w_raw_cnt;
    logic                  w_cnt_over;
    logic [ADDR_WIDTH-1:0] w_cap_cnt;
    logic                  w_cap_err;

    assign w_fifo_valid = (r_fifo_cnt != '0);
    assign w_pop        = w_fifo_valid & out_ready;
    // r_pend[1] marks the cycle mem_q holds a read issued two cycles ago;
    // only particle reads (STREAM/DRAIN) may land in the FIFO.
    assign w_push       = r_pend[1] & ((r_state == c_st_stream) | (r_state == c_st_drain));
    assign w_push_last  = (r_pend_addr1 == r_particle_cnt);
    assign w_head_last  = r_fifo_last[r_rd_ptr];

    // Every read already committed (registered, or still in the RAM pipe)
    // owns a FIFO slot; pops in the current cycle are not credited.
    assign w_occ = c_occ_w'(r_fifo_cnt) + c_occ_w'(r_mem_rden)
                 + c_occ_w'(r_pend[0]) + c_occ_w'(r_pend[1]);
    assign w_credit = (w_occ < c_occ_w'(FIFO_DEPTH));

    assign w_raw_cnt  = mem_q[ADDR_WIDTH-1:0];
    assign w_cnt_over = (w_raw_cnt > c_max_cnt);

`ifdef CELL_POS_READER_BOUNDS_CHK_EN
    assign w_cap_cnt = w_cnt_over ? c_max_cnt : w_raw_cnt;
    assign w_cap_err = w_cnt_over;
`else
    logic w_unused_cnt_over;
    assign w_unused_cnt_over = w_cnt_over;
    assign w_cap_cnt         = w_raw_cnt;
    assign w_cap_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_particle_cnt <= '0;
            r_cnt_err      <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_rden     <= 1'b0;
            r_next_addr    <= '0;
            r_pend         <= '0;
            r_pend_addr0   <= '0;
            r_pend_addr1   <= '0;
        end else begin
            r_done       <= 1'b0;
            r_mem_rden   <= 1'b0;
            r_pend       <= {r_pend[0], r_mem_rden};
            r_pend_addr0 <= r_mem_addr;
            r_pend_addr1 <= r_pend_addr0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state    <= c_st_cnt_rd;
                        r_busy     <= 1'b1;
                        r_cnt_err  <= 1'b0;
                        r_mem_addr <= '0;
                        r_mem_rden <= 1'b1;
                    end
                end
                c_st_cnt_rd: begin
                    r_state <= c_st_cnt_wait;
                end
                c_st_cnt_wait: begin
                    if (r_pend[1]) begin
                        r_particle_cnt <= w_cap_cnt;
                        r_cnt_err      <= w_cap_err;
                        if (w_cap_cnt == '0) begin
                            r_state <= c_st_done;
                            r_done  <= 1'b1;
                        end else begin
                            // First particle read goes out with the capture
                            // so the RAM pipe never idles; the FIFO is empty.
                            r_mem_rden  <= 1'b1;
                            r_mem_addr  <= c_addr_one;
                            r_next_addr <= c_addr_two;
                            r_state     <= (w_cap_cnt == c_addr_one) ? c_st_drain : c_st_stream;
                        end
                    end
                end
                c_st_stream: begin
                    if (w_credit) begin
                        r_mem_rden  <= 1'b1;
                        r_mem_addr  <= r_next_addr;
                        r_next_addr <= r_next_addr + c_addr_one;
                        if (r_next_addr == r_particle_cnt) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_pop && w_head_last) begin
                        r_state <= c_st_done;
                        r_done  <= 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= mem_q;
                r_fifo_idx[r_wr_ptr]  <= r_pend_addr1;
                r_fifo_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr              <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_cnt_w'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_cnt_w'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign particle_cnt = r_particle_cnt;
    assign cnt_err      = r_cnt_err;
    assign mem_addr     = r_mem_addr;
    assign mem_rden     = r_mem_rden;
    assign mem_wren     = 1'b0;
    assign out_valid    = w_fifo_valid;
    // Head is masked when empty so the unreset storage never shows on the port.
    assign out_data     = w_fifo_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign out_index    = w_fifo_valid ? r_fifo_idx[r_rd_ptr] : '0;
    assign out_last     = w_fifo_valid & w_head_last;

endmodule
`default_nettype wire

// File: tb/tb_cell_pos_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_pos_reader
// Function : Self-checking bench for cell_pos_reader with a 2-cycle RAM model
//            and an expected-particle scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_pos_reader;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int FD = 4;
`ifdef CELL_POS_READER_BOUNDS_CHK_EN
    localparam int   BN = 219;
    localparam logic BE = 1'b1;
`else
    localparam int   BN = 250;
    localparam logic BE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, busy, done, mem_rden, mem_wren;
    logic          out_valid, out_ready, out_last, cnt_err;
    logic [AW-1:0] particle_cnt, mem_addr, out_index;
    logic [DW-1:0] mem_q, out_data;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] q_stage;
    int            n_pass  = 0;
    int            n_total = 0;

    cell_pos_reader #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PARTICLE_NUM (220),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .particle_cnt (particle_cnt),
        .mem_addr     (mem_addr),
        .mem_rden     (mem_rden),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .cnt_err      (cnt_err)
    );

    always #5 clk = ~clk;

    // RAM with 2-cycle read latency; a non-read cycle returns a junk marker.
    always @(posedge clk) begin
        q_stage <= mem_rden ? ram[mem_addr] : {6{16'hdead}};
        mem_q   <= q_stage;
    end

    function automatic logic [DW-1:0] pat(input int c, input int i);
        return {c[15:0], i[15:0], 32'hC0DE_0000 + i, c * 97 + i * 13 + 1};
    endfunction

    task automatic load_cell(input int c, input int raw, input int n);
        exp_t e;
        ram[0] = {{11{8'h5a}}, raw[7:0]};
        for (int i = 1; i <= n; i++) begin
            ram[i] = pat(c, i);
            e.data = pat(c, i);
            e.idx  = i[7:0];
            e.last = (i == n);
            sb.push_back(e);
        end
    endtask

    task automatic tick(input logic rdy);
        @(negedge clk);
        out_ready = rdy;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, done, particle_cnt, mem_addr, mem_rden, mem_wren, out_valid,
             out_data, out_index, out_last, cnt_err} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d addr=%0d rden=%b wren=%b valid=%b idx=%0d last=%b err=%b, required all 0",
                     busy, done, particle_cnt, mem_addr, mem_rden, mem_wren, out_valid, out_index, out_last, cnt_err);
        else n_pass++;
        rst = 1'b0;
        tick(1'b0);
        n_total++;
        if ({busy, mem_rden, out_valid, mem_wren} !== 4'b0)
            $display("FAIL idle_after_reset: got busy=%b rden=%b valid=%b wren=%b, required 0",
                     busy, mem_rden, out_valid, mem_wren);
        else n_pass++;
    endtask

    task automatic test_basic();
        int   nv = 0, nd = 0, done_cyc = -1, busy_bad = 0;
        exp_t e;
        sb.delete();
        load_cell(1, 3, 3);
        tick(1'b1); start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick(1'b1);
            if (busy !== ((k >= 1) && (k <= 10))) busy_bad++;
            if (done === 1'b1) begin nd++; done_cyc = k; end
            if (out_valid === 1'b1) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_total++;
                if (k != 7 + nv || {out_data, out_index, out_last} !== e)
                    $display("FAIL basic_beat%0d: got cycle %0d idx %0d last %b data %h, required cycle %0d idx %0d last %b data %h",
                             nv, k, out_index, out_last, out_data, 7 + nv, e.idx, e.last, e.data);
                else n_pass++;
                nv++;
            end
        end
        n_total++;
        if (nv != 3) $display("FAIL basic_beats: got %0d, required 3", nv); else n_pass++;
        n_total++;
        if (nd != 1 || done_cyc != 10)
            $display("FAIL basic_done: got %0d pulses last at cycle %0d, required 1 at cycle 10", nd, done_cyc);
        else n_pass++;
        n_total++;
        if (busy_bad != 0) $display("FAIL basic_busy: got %0d wrong cycles, required 0", busy_bad); else n_pass++;
        n_total++;
        if (particle_cnt !== 8'd3) $display("FAIL basic_cnt: got %0d, required 3", particle_cnt); else n_pass++;
    endtask

    task automatic test_zero();
        int nv = 0, nd = 0, done_cyc = -1, busy_bad = 0;
        sb.delete();
        load_cell(2, 0, 0);
        tick(1'b1); start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick(1'b1);
            if (busy !== ((k >= 1) && (k <= 4))) busy_bad++;
            if (done === 1'b1) begin nd++; done_cyc = k; end
            if (out_valid !== 1'b0) nv++;
        end
        n_total++;
        if (nv != 0) $display("FAIL zero_valid: got %0d valid cycles, required 0", nv); else n_pass++;
        n_total++;
        if (nd != 1 || done_cyc != 4)
            $display("FAIL zero_done: got %0d pulses last at cycle %0d, required 1 at cycle 4", nd, done_cyc);
        else n_pass++;
        n_total++;
        if (busy_bad != 0 || particle_cnt !== 8'd0)
            $display("FAIL zero_busy_cnt: got %0d bad busy cycles cnt %0d, required 0 and 0", busy_bad, particle_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int              cum[0:511];
        int              pops = 0, issued = 0, nd = 0, outst;
        logic            rdy, prev_stall = 1'b0;
        logic [DW+AW:0]  prev_head = '0;
        exp_t            e;
        sb.delete();
        load_cell(3, 10, 10);
        tick(1'b1); start = 1'b1;
        for (int k = 0; k < 400 && nd == 0; k++) begin
            if (k > 0) begin
                rdy = (k >= 12 && k < 32) ? 1'b0 : ($urandom_range(0, 2) != 0);
                tick(rdy);
            end
            if (mem_rden === 1'b1 && k >= 2) begin
                issued++;
                outst = issued - ((k >= 2) ? cum[k-2] : 0);
                n_total++;
                if (mem_addr !== AW'(issued) || outst > FD)
                    $display("FAIL bp_issue: got addr %0d outstanding %0d at cycle %0d, required addr %0d outstanding <= %0d",
                             mem_addr, outst, k, issued, FD);
                else n_pass++;
            end
            if (prev_stall) begin
                n_total++;
                if (out_valid !== 1'b1 || {out_data, out_index, out_last} !== prev_head)
                    $display("FAIL bp_head_stable: got valid %b idx %0d, required valid 1 idx %0d",
                             out_valid, out_index, prev_head[AW:1]);
                else n_pass++;
            end
            prev_stall = out_valid && !out_ready;
            prev_head  = {out_data, out_index, out_last};
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                pops++;
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_total++;
                if ({out_data, out_index, out_last} !== e)
                    $display("FAIL bp_beat%0d: got idx %0d last %b data %h, required idx %0d last %b data %h",
                             pops, out_index, out_last, out_data, e.idx, e.last, e.data);
                else n_pass++;
            end
            cum[k] = pops;
            if (done === 1'b1) nd++;
        end
        n_total++;
        if (nd != 1 || pops != 10 || sb.size() != 0)
            $display("FAIL bp_complete: got done %0d pops %0d left %0d, required 1 10 0", nd, pops, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   nv = 0, nd = 0;
        exp_t e;
        sb.delete();
        load_cell(4, 5, 5);
        tick(1'b1); start = 1'b1;
        for (int k = 1; k <= 5; k++) tick(1'b1);
        n_total++;
        if (mem_rden !== 1'b1 || mem_addr !== 8'd2)
            $display("FAIL rstmid_inflight: got rden %b addr %0d, required 1 2", mem_rden, mem_addr);
        else n_pass++;
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        n_total++;
        if ({busy, done, particle_cnt, mem_addr, mem_rden, mem_wren, out_valid,
             out_data, out_index, out_last, cnt_err} !== '0)
            $display("FAIL rstmid_outputs: got busy=%b cnt=%0d addr=%0d rden=%b valid=%b idx=%0d, required all 0",
                     busy, particle_cnt, mem_addr, mem_rden, out_valid, out_index);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick(1'b1);
            if (out_valid !== 1'b0 || busy !== 1'b0) nv++;
        end
        n_total++;
        if (nv != 0) $display("FAIL rstmid_stale: got %0d active cycles, required 0", nv); else n_pass++;
        sb.delete();
        nv = 0;
        load_cell(5, 2, 2);
        tick(1'b1); start = 1'b1;
        for (int k = 0; k < 40 && nd == 0; k++) begin
            if (k > 0) tick(1'b1);
            if (done === 1'b1) nd++;
            if (out_valid === 1'b1) begin
                nv++;
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_total++;
                if ({out_data, out_index, out_last} !== e)
                    $display("FAIL rstmid_beat%0d: got idx %0d last %b data %h, required idx %0d last %b data %h",
                             nv, out_index, out_last, out_data, e.idx, e.last, e.data);
                else n_pass++;
            end
        end
        n_total++;
        if (nv != 2 || nd != 1) $display("FAIL rstmid_rerun: got %0d beats %0d done, required 2 1", nv, nd); else n_pass++;
    endtask

    task automatic test_restart_ignored();
        int   nv = 0, nd = 0;
        exp_t e;
        sb.delete();
        load_cell(6, 6, 6);
        tick(1'b1); start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick(1'b1);
            if (k == 5) begin
                start  = 1'b1;
                ram[0] = {{11{8'h5a}}, 8'd2};
            end
            if (done === 1'b1) nd++;
            if (out_valid === 1'b1) begin
                nv++;
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_total++;
                if ({out_data, out_index, out_last} !== e)
                    $display("FAIL restart_beat%0d: got idx %0d last %b data %h, required idx %0d last %b data %h",
                             nv, out_index, out_last, out_data, e.idx, e.last, e.data);
                else n_pass++;
            end
        end
        n_total++;
        if (nd != 1 || nv != 6 || particle_cnt !== 8'd6 || busy !== 1'b0)
            $display("FAIL restart_summary: got done %0d beats %0d cnt %0d busy %b, required 1 6 6 0",
                     nd, nv, particle_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_bounds();
        int   nv = 0, nd = 0;
        exp_t e;
        sb.delete();
        load_cell(7, 250, BN);
        tick(1'b1); start = 1'b1;
        for (int k = 0; k < 1500 && nd == 0; k++) begin
            if (k > 0) tick(1'b1);
            if (done === 1'b1) nd++;
            if (out_valid === 1'b1) begin
                nv++;
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_total++;
                if ({out_data, out_index, out_last} !== e)
                    $display("FAIL bounds_beat%0d: got idx %0d last %b, required idx %0d last %b",
                             nv, out_index, out_last, e.idx, e.last);
                else n_pass++;
            end
        end
        n_total++;
        if (nd != 1 || nv != BN || particle_cnt !== AW'(BN) || cnt_err !== BE)
            $display("FAIL bounds_run: got done %0d beats %0d cnt %0d err %b, required 1 %0d %0d %b",
                     nd, nv, particle_cnt, cnt_err, BN, BN, BE);
        else n_pass++;
        tick(1'b1);
        n_total++;
        if (cnt_err !== BE) $display("FAIL bounds_sticky: got %b, required %b", cnt_err, BE); else n_pass++;
        sb.delete();
        load_cell(8, 1, 1);
        start = 1'b1;
        tick(1'b1);
        n_total++;
        if (cnt_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL bounds_clear: got err %b busy %b, required 0 1", cnt_err, busy);
        else n_pass++;
        nd = 0;
        for (int k = 0; k < 40 && nd == 0; k++) begin
            tick(1'b1);
            if (done === 1'b1) nd++;
        end
        n_total++;
        if (nd != 1 || particle_cnt !== 8'd1) $display("FAIL bounds_rerun: got done %0d cnt %0d, required 1 1", nd, particle_cnt);
        else n_pass++;
        tick(1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_restart_ignored();
        test_bounds();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
